// File: rtl/pterm_pkg.sv
// Shared types and helpers for the product-term evaluator: reset-default
// term configuration for the classic 7-in/3-out cone and the term function.
package pterm_pkg;

  localparam int DEF_N_IN  = 7;
  localparam int DEF_N_OUT = 3;

  // x = a&b&e, y = ~(b&d&e), z = ~(c&d&e&f&g)
  localparam logic [6:0] DEF_MASK_7X3 [DEF_N_OUT] = '{7'h13, 7'h1A, 7'h7C};
  localparam logic       DEF_INV_7X3  [DEF_N_OUT] = '{1'b0, 1'b1, 1'b1};

  // Unselected bits are forced high so they drop out of the AND; an empty mask yields 1.
  function automatic logic pterm_eval(input logic [31:0] vec,
                                      input logic [31:0] mask,
                                      input logic        inv);
    return (&(vec | ~mask)) ^ inv;
  endfunction

  function automatic logic [31:0] def_mask(input int n_in, input int k);
    logic [1:0] k2;
    k2 = k[1:0];
    if (n_in == DEF_N_IN && k >= 0 && k < DEF_N_OUT) return {25'd0, DEF_MASK_7X3[k2]};
    return 32'd0;
  endfunction

  function automatic logic def_inv(input int n_in, input int k);
    logic [1:0] k2;
    k2 = k[1:0];
    if (n_in == DEF_N_IN && k >= 0 && k < DEF_N_OUT) return DEF_INV_7X3[k2];
    return 1'b0;
  endfunction

endpackage

// File: rtl/pterm_eval_pipe_if.sv
// Input/output valid-ready streams of the product-term evaluator.
interface pterm_eval_pipe_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_vec;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/pterm_chan.sv
// One output channel: its term configuration, the stage-1 raw AND with the
// inversion captured at accept, and a saturating hit counter.
module pterm_chan
  import pterm_pkg::*;
#(
  parameter int              N_IN     = 7,
  parameter int              CNT_W    = 8,
  parameter logic [N_IN-1:0] DEF_MASK = '0,
  parameter logic            DEF_INV  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [N_IN-1:0]  cfg_mask_i,
  input  logic             cfg_inv_i,
  input  logic             load_i,
  input  logic [N_IN-1:0]  vec_i,
  input  logic             cnt_clr_i,
  input  logic             cnt_inc_i,
  output logic             and_o,
  output logic             inv_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_IN-1:0]  mask_q, mask_d;
  logic             inv_q, inv_d;
  logic             and_q, and_d;
  logic             s1_inv_q, s1_inv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mask_d   = mask_q;
    inv_d    = inv_q;
    and_d    = and_q;
    s1_inv_d = s1_inv_q;
    cnt_d    = cnt_q;
    if (cfg_we_i) begin
      mask_d = cfg_mask_i;
      inv_d  = cfg_inv_i;
    end
    // Uses the pre-write config, so a write in the accept cycle misses this vector.
    if (load_i) begin
      and_d    = pterm_eval(32'(vec_i), 32'(mask_q), 1'b0);
      s1_inv_d = inv_q;
    end
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_inc_i && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= DEF_MASK;
      inv_q    <= DEF_INV;
      and_q    <= 1'b0;
      s1_inv_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mask_q   <= mask_d;
      inv_q    <= inv_d;
      and_q    <= and_d;
      s1_inv_q <= s1_inv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign and_o = and_q;
  assign inv_o = s1_inv_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/pterm_eval_pipe.sv
// Two-stage pipelined AND/NAND product-term evaluator with valid/ready
// streams, runtime term configuration and per-channel hit counters.
module pterm_eval_pipe
  import pterm_pkg::*;
#(
  parameter  int N_IN  = 7,
  parameter  int N_OUT = 3,
  parameter  int CNT_W = 8,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  pterm_eval_pipe_if.slave       bus,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [N_IN-1:0]        cfg_mask,
  input  logic                   cfg_inv,
  input  logic                   cnt_clr,
  output logic [N_OUT*CNT_W-1:0] hit_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_vec_q, out_vec_d;
  logic [N_OUT-1:0] s1_and, s1_inv;
  logic             advance, s1_free, accept, fire;

  // S2 moves when empty or drained; S1 can also fill behind a stalled S2 if it is empty.
  assign advance = ~out_valid_q | bus.out_ready;
  assign s1_free = ~s1_valid_q | advance;
  assign accept  = bus.in_valid & s1_free;
  assign fire    = out_valid_q & bus.out_ready;

  assign bus.in_ready  = s1_free;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_vec_d = s1_and ^ s1_inv;
    end
    if (s1_free) s1_valid_d = accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
      pterm_chan #(
        .N_IN    (N_IN),
        .CNT_W   (CNT_W),
        .DEF_MASK(N_IN'(def_mask(N_IN, gi))),
        .DEF_INV (def_inv(N_IN, gi))
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .cfg_we_i  (cfg_we && (cfg_idx == IDX_W'(gi))),
        .cfg_mask_i(cfg_mask),
        .cfg_inv_i (cfg_inv),
        .load_i    (accept),
        .vec_i     (bus.in_vec),
        .cnt_clr_i (cnt_clr),
        .cnt_inc_i (fire & out_vec_q[gi]),
        .and_o     (s1_and[gi]),
        .inv_o     (s1_inv[gi]),
        .cnt_o     (hit_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pterm_eval_pipe.sv
// Bench for pterm_eval_pipe (7 in, 3 out, 2-bit counters): expected results
// queue at accept and are checked as the DUT hands them out.
module tb_pterm_eval_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [6:0] cfg_mask = '0;
  logic       cfg_inv = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [5:0] hit_cnt;

  always #5 clk = ~clk;

  pterm_eval_pipe_if #(.N_IN(7), .N_OUT(3)) bus ();

  pterm_eval_pipe #(.N_IN(7), .N_OUT(3), .CNT_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_mask(cfg_mask),
    .cfg_inv (cfg_inv),
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt)
  );

  typedef struct {
    logic [6:0] vec;
    logic [2:0] exp;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [2:0] sb[$];
  int         pop_cyc[$];
  vec_t       tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [6:0] v);
    logic x, y, z;
    x = v[0] & v[1] & v[4];
    y = ~(v[1] & v[3] & v[4]);
    z = ~(v[2] & v[3] & v[4] & v[5] & v[6]);
    return {z, y, x};
  endfunction

  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected no output", bus.out_vec);
      end else begin
        e = sb.pop_front();
        check("out_vec", 32'(bus.out_vec), 32'(e));
        $display("out  cyc=%0d vec=%03b exp=%03b", cyc, bus.out_vec, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] v, input logic [2:0] e, output int acc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    acc = cyc;
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      $display("in   cyc=%0d vec=%02h exp=%03b", cyc, v, e);
      tick(1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_left", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         acc;
    int         accepts;
    int         k2;
    logic [6:0] vv[3];
    logic [2:0] ee[3];

    tbl[0] = '{7'h7F, 3'b001};
    tbl[1] = '{7'h00, 3'b110};
    tbl[2] = '{7'h13, 3'b111};
    tbl[3] = '{7'h1A, 3'b100};
    tbl[4] = '{7'h7C, 3'b010};
    tbl[5] = '{7'h7B, 3'b101};

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_vec", 32'(bus.out_vec), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    tick(1);

    // Defaults, latency, table vectors
    pop_cyc.delete();
    send(tbl[0].vec, tbl[0].exp, acc);
    drain(10);
    check("latency", (pop_cyc.size() > 0) ? 32'(pop_cyc[0] - acc) : 32'hFFFF, 2);
    for (int i = 1; i < 6; i++) send(tbl[i].vec, tbl[i].exp, acc);
    drain(10);

    // Exhaustive stream, one per cycle
    pop_cyc.delete();
    for (int v = 0; v < 128; v++) send(7'(v), model(7'(v)), acc);
    drain(10);
    check("stream_count", 32'(pop_cyc.size()), 128);
    check("stream_span", (pop_cyc.size() == 128) ? 32'(pop_cyc[127] - pop_cyc[0]) : 32'hFFFF, 127);

    // Backpressure
    vv = '{7'h7F, 7'h00, 7'h13};
    ee = '{3'b001, 3'b110, 3'b111};
    accepts = 0;
    k2 = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k2 < 3) begin
        bus.in_valid = 1'b1;
        bus.in_vec   = vv[k2];
      end
      if (bus.in_ready === 1'b1 && k2 < 3) begin
        sb.push_back(ee[k2]);
        k2++;
        accepts++;
      end
      if (k >= 2) begin
        check("bp_hold_valid", 32'(bus.out_valid), 1);
        check("bp_hold_vec", 32'(bus.out_vec), 32'(ee[0]));
      end
      tick(1);
    end
    check("bp_accepts", 32'(accepts), 2);
    check("bp_in_ready_low", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(bus.in_ready), 1);
    sb.push_back(ee[2]);
    tick(1);
    bus.in_valid = 1'b0;
    drain(10);

    // Config write in the accept cycle, then effective; out-of-range index ignored
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_mask = 7'h01;
    cfg_inv  = 1'b1;
    send(7'h13, 3'b111, acc);
    cfg_we = 1'b0;
    send(7'h01, 3'b110, acc);
    cfg_we   = 1'b1;
    cfg_idx  = 2'd3;
    cfg_mask = 7'h00;
    cfg_inv  = 1'b0;
    tick(1);
    cfg_we = 1'b0;
    send(7'h7F, 3'b000, acc);
    drain(10);

    // Saturating counters and clear priority
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("cnt_cleared", 32'(hit_cnt), 0);
    for (int i = 0; i < 2; i++) send(7'h00, 3'b111, acc);
    drain(10);
    tick(1);
    check("cnt_two", 32'(hit_cnt), 32'h2A);
    for (int i = 0; i < 3; i++) send(7'h00, 3'b111, acc);
    drain(10);
    tick(1);
    check("cnt_saturated", 32'(hit_cnt[1:0]), 3);
    check("cnt_all_sat", 32'(hit_cnt), 32'h3F);
    send(7'h00, 3'b111, acc);
    tick(1);
    check("clr_hit_valid", 32'(bus.out_valid), 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("clr_over_hit", 32'(hit_cnt), 0);
    drain(10);

    // Asynchronous reset with two vectors in flight
    send(7'h7F, 3'b001, acc);
    send(7'h00, 3'b110, acc);
    check("inflight_valid", 32'(bus.out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_vec", 32'(bus.out_vec), 0);
    sb.delete();
    tick(2);
    rst = 1'b0;
    tick(6);
    check("post_rst_idle", 32'(bus.out_valid), 0);
    send(7'h13, 3'b111, acc);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
